detector_sentido: RTL and testbench

//   Front-end for the parking car counter. Reads two light-barrier sensors
//   (A = street side, B = lot side) and decodes the direction of each car

---
 rtl/detector_sentido.sv | 166 ++++++++++++++++
 tb/tb_detector_sentido.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/detector_sentido.sv
// Direction decoder for the parking counter: synchronises and debounces two
// light-barrier sensors, then tracks each car through the barrier zone.
module detector_sentido #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic entrada,
    output logic salida,
    output logic error,
    output logic ocupado
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_E1   = 3'd1,
        ST_E2   = 3'd2,
        ST_E3   = 3'd3,
        ST_S1   = 3'd4,
        ST_S2   = 3'd5,
        ST_S3   = 3'd6,
        ST_WAIT = 3'd7
    } state_t;

    // Bit 1 carries sensor A, bit 0 carries sensor B throughout.
    logic [1:0]    s1_r;
    logic [1:0]    s2_r;
    logic [1:0]    filt_r;
    logic [CW-1:0] cnt_r [2];

    state_t state_r, state_nxt_s;
    logic   entrada_r, salida_r, error_r, ocupado_r;
    logic   entrada_nxt_s, salida_nxt_s, error_nxt_s;

    // Two-flop synchroniser for both raw barrier inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 2'b00;
            s2_r <= 2'b00;
        end else begin
            s1_r <= {sensor_a, sensor_b};
            s2_r <= s1_r;
        end
    end

    // Per-sensor debouncer: a new level must persist DEB_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r <= 2'b00;
            for (int i = 0; i < 2; i++) cnt_r[i] <= CNT_ZERO;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2_r[i] == filt_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_MAX) begin
                    filt_r[i] <= s2_r[i];
                    cnt_r[i]  <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Direction FSM next-state and event decode on the filtered {a,b} pair
    always_comb begin
        state_nxt_s   = state_r;
        entrada_nxt_s = 1'b0;
        salida_nxt_s  = 1'b0;
        error_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: case (filt_r)
                2'b10:   state_nxt_s = ST_E1;
                2'b01:   state_nxt_s = ST_S1;
                2'b11:   state_nxt_s = ST_WAIT;
                default: state_nxt_s = ST_IDLE;
            endcase
            ST_E1: case (filt_r)
                2'b11:   state_nxt_s = ST_E2;
                2'b00:   state_nxt_s = ST_IDLE;
                2'b01:   state_nxt_s = ST_WAIT;
                default: state_nxt_s = ST_E1;
            endcase
            ST_E2: case (filt_r)
                2'b01:   state_nxt_s = ST_E3;
                2'b10:   state_nxt_s = ST_E1;
                2'b00:   state_nxt_s = ST_WAIT;
                default: state_nxt_s = ST_E2;
            endcase
            ST_E3: case (filt_r)
                2'b00: begin
                    state_nxt_s   = ST_IDLE;
                    entrada_nxt_s = 1'b1;
                end
                2'b11:   state_nxt_s = ST_E2;
                2'b10:   state_nxt_s = ST_WAIT;
                default: state_nxt_s = ST_E3;
            endcase
            ST_S1: case (filt_r)
                2'b11:   state_nxt_s = ST_S2;
                2'b00:   state_nxt_s = ST_IDLE;
                2'b10:   state_nxt_s = ST_WAIT;
                default: state_nxt_s = ST_S1;
            endcase
            ST_S2: case (filt_r)
                2'b10:   state_nxt_s = ST_S3;
                2'b01:   state_nxt_s = ST_S1;
                2'b00:   state_nxt_s = ST_WAIT;
                default: state_nxt_s = ST_S2;
            endcase
            ST_S3: case (filt_r)
                2'b00: begin
                    state_nxt_s  = ST_IDLE;
                    salida_nxt_s = 1'b1;
                end
                2'b11:   state_nxt_s = ST_S2;
                2'b01:   state_nxt_s = ST_WAIT;
                default: state_nxt_s = ST_S3;
            endcase
            ST_WAIT: begin
                if (filt_r == 2'b00) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        // Error fires only on the entry edge into WAIT, not while it is held
        if ((state_nxt_s == ST_WAIT) && (state_r != ST_WAIT)) begin
            error_nxt_s = 1'b1;
        end else begin
            error_nxt_s = 1'b0;
        end
    end

    // State and output registers; ocupado tracks the registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            entrada_r <= 1'b0;
            salida_r  <= 1'b0;
            error_r   <= 1'b0;
            ocupado_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            entrada_r <= entrada_nxt_s;
            salida_r  <= salida_nxt_s;
            error_r   <= error_nxt_s;
            ocupado_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign entrada = entrada_r;
    assign salida  = salida_r;
    assign error   = error_r;
    assign ocupado = ocupado_r;

endmodule

// File: tb/tb_detector_sentido.sv
// Bench for detector_sentido: directed crossing scenarios plus random sensor
// activity, every cycle compared against a behavioural model of the decoder.
module tb_detector_sentido;

    localparam int DEB = 4;
    localparam int IDLE = 0, E1 = 1, E2 = 2, E3 = 3, S1 = 4, S2 = 5, S3 = 6, WT = 7;

    logic clk = 1'b0;
    logic rst_n, sensor_a, sensor_b;
    logic entrada, salida, error, ocupado;

    detector_sentido #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .entrada(entrada), .salida(salida), .error(error), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int seen_ent, seen_sal, seen_err, seen_ocu, ent_cyc, t0;

    // Model state: raw-sample delay line, debounce histories, crossing phase
    int       m_state;
    bit       m_fa, m_fb;
    bit [1:0] pa, pb;
    bit [DEB-1:0] ha, hb;
    int       na, nb;
    bit       e_ent, e_sal, e_err, e_ocu;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Crossing phase transitions, written straight from the decode table
    function automatic int fsm_next(input int st, input bit [1:0] ab,
                                    output bit ent, output bit sal);
        int n = st;
        ent = 1'b0;
        sal = 1'b0;
        case (st)
            IDLE: if (ab == 2'b10) n = E1; else if (ab == 2'b01) n = S1; else if (ab == 2'b11) n = WT;
            E1:   if (ab == 2'b11) n = E2; else if (ab == 2'b00) n = IDLE; else if (ab == 2'b01) n = WT;
            E2:   if (ab == 2'b01) n = E3; else if (ab == 2'b10) n = E1; else if (ab == 2'b00) n = WT;
            E3:   if (ab == 2'b00) begin n = IDLE; ent = 1'b1; end
                  else if (ab == 2'b11) n = E2; else if (ab == 2'b10) n = WT;
            S1:   if (ab == 2'b11) n = S2; else if (ab == 2'b00) n = IDLE; else if (ab == 2'b10) n = WT;
            S2:   if (ab == 2'b10) n = S3; else if (ab == 2'b01) n = S1; else if (ab == 2'b00) n = WT;
            S3:   if (ab == 2'b00) begin n = IDLE; sal = 1'b1; end
                  else if (ab == 2'b11) n = S2; else if (ab == 2'b01) n = WT;
            default: if (ab == 2'b00) n = IDLE;
        endcase
        return n;
    endfunction

    // Accept the opposite level once the last DEB synced samples all show it
    function automatic void deb(input bit s2, inout bit filt, inout bit [DEB-1:0] h, inout int n);
        h = (h << 1) | DEB'(s2);
        if (n < DEB) n++;
        if (n == DEB && h == (filt ? {DEB{1'b0}} : {DEB{1'b1}})) begin
            filt = !filt;
            n = 0;
        end
    endfunction

    task automatic model_reset();
        m_state = IDLE; m_fa = 1'b0; m_fb = 1'b0;
        pa = 2'b00; pb = 2'b00; ha = '0; hb = '0; na = 0; nb = 0;
        e_ent = 1'b0; e_sal = 1'b0; e_err = 1'b0; e_ocu = 1'b0;
    endtask

    task automatic model_update();
        bit ent, sal;
        int nxt;
        if (!rst_n) begin
            model_reset();
        end else begin
            nxt   = fsm_next(m_state, {m_fa, m_fb}, ent, sal);
            e_err = (nxt == WT) && (m_state != WT);
            e_ent = ent; e_sal = sal;
            m_state = nxt;
            e_ocu = (nxt != IDLE);
            deb(pa[1], m_fa, ha, na);
            deb(pb[1], m_fb, hb, nb);
            pa = {pa[0], sensor_a};
            pb = {pb[0], sensor_b};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        chk("entrada", entrada, e_ent);
        chk("salida", salida, e_sal);
        chk("error", error, e_err);
        chk("ocupado", ocupado, e_ocu);
        if (entrada) begin seen_ent++; ent_cyc = cyc; end
        if (salida) seen_sal++;
        if (error) seen_err++;
        if (ocupado) seen_ocu++;
    endtask

    task automatic hold(input bit a, input bit b, input int n);
        sensor_a = a; sensor_b = b;
        repeat (n) step();
    endtask

    task automatic clr();
        seen_ent = 0; seen_sal = 0; seen_err = 0; seen_ocu = 0; ent_cyc = -1;
    endtask

    initial begin
        rst_n = 1'b0; sensor_a = 1'b0; sensor_b = 1'b0;
        model_reset(); clr();
        repeat (3) step();
        rst_n = 1'b1;
        hold(0, 0, 5);

        // Entry crossing
        clr();
        hold(0, 0, 10); hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        t0 = cyc;
        hold(0, 0, 10);
        chk("entry_count", seen_ent, 1);
        chk("entry_latency", ent_cyc - t0, 7);
        chk("entry_no_sal", seen_sal, 0);
        chk("entry_no_err", seen_err, 0);

        // Exit crossing
        clr();
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
        chk("exit_count", seen_sal, 1);
        chk("exit_no_ent", seen_ent, 0);
        chk("exit_no_err", seen_err, 0);

        // Reversal, then a crossing with a back-step
        clr();
        hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
        chk("rev_no_pulse", seen_ent + seen_sal + seen_err, 0);
        clr();
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
        chk("rev_entry", seen_ent, 1);

        // Glitch filtering
        clr();
        hold(1, 0, 3); hold(0, 0, 12);
        chk("glitch3_ocu", seen_ocu, 0);
        clr();
        hold(1, 0, 4); hold(0, 0, 12);
        chk("glitch4_ocu", int'(seen_ocu > 0), 1);
        chk("glitch4_no_pulse", seen_ent + seen_sal + seen_err, 0);

        // Illegal jump straight to 11
        clr();
        hold(1, 1, 20); hold(0, 0, 12);
        chk("illegal_err", seen_err, 1);
        chk("illegal_no_evt", seen_ent + seen_sal, 0);

        // Asynchronous reset while in E3
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        chk("pre_rst_ocu", ocupado, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ocu", ocupado, 0);
        chk("rst_async_ent", entrada, 0);
        model_reset();
        clr();
        hold(0, 0, 3);
        rst_n = 1'b1;
        hold(0, 0, 20);
        chk("rst_no_entrada", seen_ent, 0);

        // Release from reset with both beams already blocked
        rst_n = 1'b0;
        hold(1, 1, 3);
        rst_n = 1'b1;
        clr();
        hold(1, 1, 12);
        chk("blocked_rel_err", seen_err, 1);
        hold(0, 0, 12);

        // Random sensor activity
        clr();
        for (int i = 0; i < 400; i++)
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
        hold(0, 0, 12);
        chk("rand_idle_end", ocupado, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
